// File: rtl/sddr_init_sequencer_pkg.sv
// Shared DDR3 init definitions: command encodings, mode-register indices
// and helpers used by the init sequencer.
package sddr_pkg;

  typedef enum logic [1:0] {
    CMD_DESELECT,
    CMD_NOP,
    CMD_MRS,
    CMD_ZQCL
  } cmd_t;

  localparam int unsigned MR0 = 0;
  localparam int unsigned MR1 = 1;
  localparam int unsigned MR2 = 2;
  localparam int unsigned MR3 = 3;

  localparam int unsigned MR1_WL_BIT = 7;
  localparam int unsigned ZQCL_A10   = 10;

  // Command to {cs_n, ras_n, cas_n, we_n}.
  function automatic logic [3:0] cmd_bits(input cmd_t cmd);
    case (cmd)
      CMD_NOP:  cmd_bits = 4'b0111;
      CMD_MRS:  cmd_bits = 4'b0000;
      CMD_ZQCL: cmd_bits = 4'b0110;
      default:  cmd_bits = 4'b1111;
    endcase
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    max2 = (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sddr_init_sequencer_delay_counter.sv
// Loadable down-counter that saturates at zero; zero_o flags expiry.
module sddr_delay_counter #(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // Load takes priority; otherwise count down and hold at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= RESET_VAL;
    else       count_q <= count_d;
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/sddr_init_sequencer.sv
// DDR3 power-up / initialization sequencer driving the PHY command bus
// until init_done_o rises.
module sddr_init_sequencer
  import sddr_pkg::*;
#(
  parameter int unsigned BANK_BITS       = 3,
  parameter int unsigned ROW_BITS        = 13,
  parameter int unsigned DATA_BITS       = 16,
  parameter int unsigned RESET_CYCLES    = 60606,
  parameter int unsigned CKE_WAIT_CYCLES = 151516,
  parameter int unsigned TXPR_CYCLES     = 100,
  parameter int unsigned TMRD_CYCLES     = 4,
  parameter int unsigned TMOD_CYCLES     = 12,
  parameter int unsigned TZQINIT_CYCLES  = 512,
  parameter int unsigned WL_CYCLES       = 256,
  parameter logic [15:0] MR0_VAL         = 16'h0000,
  parameter logic [15:0] MR1_VAL         = 16'h0000,
  parameter logic [15:0] MR2_VAL         = 16'h0000,
  parameter logic [15:0] MR3_VAL         = 16'h0000
) (
  input  logic                                     in_ddr_clock_i,
  input  logic                                     in_ddr_reset_i,
  output logic                                     ddr3_reset_n_o,
  output logic                                     ctl_cke_o,
  output logic                                     ctl_cs_n_o,
  output logic                                     ctl_ras_n_o,
  output logic                                     ctl_cas_n_o,
  output logic                                     ctl_we_n_o,
  output logic [ROW_BITS+$clog2(DATA_BITS/8)-1:0]  ctl_addr_o,
  output logic [BANK_BITS-1:0]                     ctl_ba_o,
  output logic                                     ctl_odt_o,
  output logic                                     ctl_write_level_o,
  output logic                                     init_done_o
);

  localparam int unsigned AW   = ROW_BITS + $clog2(DATA_BITS / 8);
  localparam int unsigned MAXC = max2(max2(max2(RESET_CYCLES, CKE_WAIT_CYCLES),
                                           max2(TXPR_CYCLES, TMRD_CYCLES)),
                                      max2(max2(TMOD_CYCLES, TZQINIT_CYCLES), WL_CYCLES));
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  if (RESET_CYCLES == 0 || CKE_WAIT_CYCLES == 0 || TXPR_CYCLES == 0 ||
      TMRD_CYCLES == 0 || TMOD_CYCLES == 0 || TZQINIT_CYCLES == 0) begin : g_bad_timing
    $error("sddr_init_sequencer: only WL_CYCLES may be zero");
  end

  // Each command state lasts its full tX: the command is issued on the
  // entry cycle and the remaining cycles are the post-command wait.
  typedef enum logic [3:0] {
    S_RESET_HOLD, S_CKE_WAIT, S_TXPR, S_MRS2, S_MRS3, S_MRS1, S_MRS0,
    S_ZQCL, S_WL_ENTER, S_WL_ACTIVE, S_WL_EXIT, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            cnt_load;
  logic [CW-1:0]   cnt_load_val;
  logic            cnt_zero;
  cmd_t            cmd;

  logic            reset_n_q, reset_n_d;
  logic            cke_q, cke_d;
  logic [3:0]      cmd_q, cmd_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [BANK_BITS-1:0] ba_q, ba_d;
  logic            odt_q, odt_d;
  logic            wl_q, wl_d;
  logic            done_q, done_d;

  function automatic logic [CW-1:0] span(input int unsigned cycles);
    span = CW'(cycles - 1);
  endfunction

  sddr_delay_counter #(
    .WIDTH     (CW),
    .RESET_VAL (CW'(RESET_CYCLES - 1))
  ) u_delay (
    .clk_i      (in_ddr_clock_i),
    .rst_i      (in_ddr_reset_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .zero_o     (cnt_zero)
  );

  // State register.
  always_ff @(posedge in_ddr_clock_i or posedge in_ddr_reset_i) begin
    if (in_ddr_reset_i) state_q <= S_RESET_HOLD;
    else                state_q <= state_d;
  end

  // Next state: advance when the counter expires, loading the new span.
  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    if (cnt_zero) begin
      unique case (state_q)
        S_RESET_HOLD: begin state_d = S_CKE_WAIT;  cnt_load_val = span(CKE_WAIT_CYCLES); end
        S_CKE_WAIT:   begin state_d = S_TXPR;      cnt_load_val = span(TXPR_CYCLES);     end
        S_TXPR:       begin state_d = S_MRS2;      cnt_load_val = span(TMRD_CYCLES);     end
        S_MRS2:       begin state_d = S_MRS3;      cnt_load_val = span(TMRD_CYCLES);     end
        S_MRS3:       begin state_d = S_MRS1;      cnt_load_val = span(TMRD_CYCLES);     end
        S_MRS1:       begin state_d = S_MRS0;      cnt_load_val = span(TMOD_CYCLES);     end
        S_MRS0:       begin state_d = S_ZQCL;      cnt_load_val = span(TZQINIT_CYCLES);  end
        S_ZQCL: begin
          if (WL_CYCLES == 0) begin
            state_d = S_DONE;
          end else begin
            state_d      = S_WL_ENTER;
            cnt_load_val = span(TMOD_CYCLES);
          end
        end
        S_WL_ENTER:   begin state_d = S_WL_ACTIVE; cnt_load_val = span(WL_CYCLES);       end
        S_WL_ACTIVE:  begin state_d = S_WL_EXIT;   cnt_load_val = span(TMOD_CYCLES);     end
        S_WL_EXIT:    state_d = S_DONE;
        S_DONE:       state_d = S_DONE;
        default:      state_d = S_RESET_HOLD;
      endcase
      cnt_load = (state_d != state_q);
    end
  end

  // Outputs for the upcoming cycle, decoded from the next state.
  always_comb begin
    cmd       = CMD_NOP;
    ba_d      = '0;
    addr_d    = '0;
    reset_n_d = (state_d != S_RESET_HOLD);
    cke_d     = !(state_d inside {S_RESET_HOLD, S_CKE_WAIT});
    if (!cke_d) begin
      cmd = CMD_DESELECT;
    end else if (cnt_load) begin
      unique case (state_d)
        S_MRS2:     begin cmd = CMD_MRS; ba_d = BANK_BITS'(MR2); addr_d = AW'(MR2_VAL); end
        S_MRS3:     begin cmd = CMD_MRS; ba_d = BANK_BITS'(MR3); addr_d = AW'(MR3_VAL); end
        S_MRS1:     begin cmd = CMD_MRS; ba_d = BANK_BITS'(MR1); addr_d = AW'(MR1_VAL); end
        S_MRS0:     begin cmd = CMD_MRS; ba_d = BANK_BITS'(MR0); addr_d = AW'(MR0_VAL); end
        S_ZQCL:     begin cmd = CMD_ZQCL; addr_d = AW'(32'd1 << ZQCL_A10); end
        S_WL_ENTER: begin
          cmd    = CMD_MRS;
          ba_d   = BANK_BITS'(MR1);
          addr_d = AW'(MR1_VAL | 16'(32'd1 << MR1_WL_BIT));
        end
        S_WL_EXIT:  begin cmd = CMD_MRS; ba_d = BANK_BITS'(MR1); addr_d = AW'(MR1_VAL); end
        default:    cmd = CMD_NOP;
      endcase
    end
    cmd_d  = cmd_bits(cmd);
    wl_d   = (state_d == S_WL_ACTIVE);
    odt_d  = (state_d == S_WL_ACTIVE);
    done_d = (state_d == S_DONE);
  end

  // Output registers.
  always_ff @(posedge in_ddr_clock_i or posedge in_ddr_reset_i) begin
    if (in_ddr_reset_i) begin
      reset_n_q <= 1'b0;
      cke_q     <= 1'b0;
      cmd_q     <= 4'b1111;
      addr_q    <= '0;
      ba_q      <= '0;
      odt_q     <= 1'b0;
      wl_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      reset_n_q <= reset_n_d;
      cke_q     <= cke_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      ba_q      <= ba_d;
      odt_q     <= odt_d;
      wl_q      <= wl_d;
      done_q    <= done_d;
    end
  end

  assign ddr3_reset_n_o    = reset_n_q;
  assign ctl_cke_o         = cke_q;
  assign {ctl_cs_n_o, ctl_ras_n_o, ctl_cas_n_o, ctl_we_n_o} = cmd_q;
  assign ctl_addr_o        = addr_q;
  assign ctl_ba_o          = ba_q;
  assign ctl_odt_o         = odt_q;
  assign ctl_write_level_o = wl_q;
  assign init_done_o       = done_q;

endmodule

// File: tb/tb_sddr_init_sequencer.sv
// Bench for sddr_init_sequencer: directed cycle vectors, a per-cycle
// expected-bus model, an async mid-sequence reset, and a WL_CYCLES=0 instance.
module tb_sddr_init_sequencer;

  localparam logic [15:0] MR0V = 16'h1520;
  localparam logic [15:0] MR1V = 16'h0044;
  localparam logic [15:0] MR2V = 16'h0008;
  localparam logic [15:0] MR3V = 16'hC004;   // top bits drop on a 14-bit bus

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_rstn, a_cke, a_cs, a_ras, a_cas, a_we, a_odt, a_wl, a_done;
  logic [13:0] a_addr;
  logic [2:0]  a_ba;
  logic        b_rstn, b_cke, b_cs, b_ras, b_cas, b_we, b_odt, b_wl, b_done;
  logic [13:0] b_addr;
  logic [2:0]  b_ba;

  sddr_init_sequencer #(
    .RESET_CYCLES(10), .CKE_WAIT_CYCLES(20), .TXPR_CYCLES(5), .TMRD_CYCLES(4),
    .TMOD_CYCLES(12), .TZQINIT_CYCLES(32), .WL_CYCLES(16),
    .MR0_VAL(MR0V), .MR1_VAL(MR1V), .MR2_VAL(MR2V), .MR3_VAL(MR3V)
  ) dut (
    .in_ddr_clock_i(clk), .in_ddr_reset_i(rst), .ddr3_reset_n_o(a_rstn),
    .ctl_cke_o(a_cke), .ctl_cs_n_o(a_cs), .ctl_ras_n_o(a_ras), .ctl_cas_n_o(a_cas),
    .ctl_we_n_o(a_we), .ctl_addr_o(a_addr), .ctl_ba_o(a_ba), .ctl_odt_o(a_odt),
    .ctl_write_level_o(a_wl), .init_done_o(a_done)
  );

  sddr_init_sequencer #(
    .RESET_CYCLES(10), .CKE_WAIT_CYCLES(20), .TXPR_CYCLES(5), .TMRD_CYCLES(4),
    .TMOD_CYCLES(12), .TZQINIT_CYCLES(32), .WL_CYCLES(0),
    .MR0_VAL(MR0V), .MR1_VAL(MR1V), .MR2_VAL(MR2V), .MR3_VAL(MR3V)
  ) dut_nowl (
    .in_ddr_clock_i(clk), .in_ddr_reset_i(rst), .ddr3_reset_n_o(b_rstn),
    .ctl_cke_o(b_cke), .ctl_cs_n_o(b_cs), .ctl_ras_n_o(b_ras), .ctl_cas_n_o(b_cas),
    .ctl_we_n_o(b_we), .ctl_addr_o(b_addr), .ctl_ba_o(b_ba), .ctl_odt_o(b_odt),
    .ctl_write_level_o(b_wl), .init_done_o(b_done)
  );

  // Bus layout: {reset_n, cke, cs_n, ras_n, cas_n, we_n, ba[2:0], addr[13:0], odt, wl, done}
  logic [25:0] bus_a, bus_b;
  assign bus_a = {a_rstn, a_cke, a_cs, a_ras, a_cas, a_we, a_ba, a_addr, a_odt, a_wl, a_done};
  assign bus_b = {b_rstn, b_cke, b_cs, b_ras, b_cas, b_we, b_ba, b_addr, b_odt, b_wl, b_done};

  localparam logic [25:0] RESET_BUS = {1'b0, 1'b0, 4'hF, 3'd0, 14'h0, 1'b0, 1'b0, 1'b0};

  typedef struct {
    int          cyc;
    logic        rst_n;
    logic        cke;
    logic [3:0]  cmd;
    logic [2:0]  ba;
    logic [13:0] addr;
    logic        odt;
    logic        wl;
    logic        done;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cur_cyc  = 0;

  function automatic logic [25:0] pack(input vec_t v);
    pack = {v.rst_n, v.cke, v.cmd, v.ba, v.addr, v.odt, v.wl, v.done};
  endfunction

  // Expected bus for a given cycle after reset release, from the timing plan.
  function automatic logic [25:0] exp_bus(input int c, input bit wl_en);
    logic        rn, ck, od, dn;
    logic [3:0]  cm;
    logic [2:0]  ba;
    logic [13:0] ad;
    rn = (c >= 10);
    ck = (c >= 30);
    cm = ck ? 4'h7 : 4'hF;
    ba = 3'd0;
    ad = 14'h0;
    case (c)
      35: begin cm = 4'h0; ba = 3'd2; ad = 14'h0008; end
      39: begin cm = 4'h0; ba = 3'd3; ad = 14'h0004; end
      43: begin cm = 4'h0; ba = 3'd1; ad = 14'h0044; end
      47: begin cm = 4'h0; ba = 3'd0; ad = 14'h1520; end
      59: begin cm = 4'h6; ba = 3'd0; ad = 14'h0400; end
      91:  if (wl_en) begin cm = 4'h0; ba = 3'd1; ad = 14'h00C4; end
      119: if (wl_en) begin cm = 4'h0; ba = 3'd1; ad = 14'h0044; end
      default: ;
    endcase
    od = wl_en && (c >= 103) && (c <= 118);
    dn = wl_en ? (c >= 131) : (c >= 91);
    exp_bus = {rn, ck, cm, ba, ad, od, od, dn};
  endfunction

  // Only deselect while cke is low; only NOP/MRS/ZQCL once it is high.
  function automatic logic legal(input logic [25:0] b);
    if (!b[24]) legal = (b[23:20] == 4'hF);
    else        legal = (b[23:20] == 4'h7) || (b[23:20] == 4'h0) || (b[23:20] == 4'h6);
  endfunction

  task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %07h expected %07h", name, cur_cyc, act, exp);
    end
  endtask

  // Walk cycles 0..ncyc after a release at a negedge; optionally assert
  // reset in the middle of cycle abort_at and stop there.
  task automatic run_seq(input int ncyc, input int abort_at);
    int vi;
    vi = 0;
    for (int c = 0; c <= ncyc; c++) begin
      cur_cyc = c;
      #1;
      check("model_wl",   bus_a, exp_bus(c, 1'b1));
      check("model_nowl", bus_b, exp_bus(c, 1'b0));
      check("legal_wl",   26'(legal(bus_a)), 26'd1);
      check("legal_nowl", 26'(legal(bus_b)), 26'd1);
      while (vi < vecs.size() && vecs[vi].cyc == c) begin
        check("vector", bus_a, pack(vecs[vi]));
        vi++;
      end
      if (c == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check("async_rst_wl",   bus_a, RESET_BUS);
        check("async_rst_nowl", bus_b, RESET_BUS);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    //                cyc  rn cke cmd   ba    addr       odt wl done
    vecs.push_back('{   0, 0, 0, 4'hF, 3'd0, 14'h0000, 0, 0, 0});
    vecs.push_back('{   9, 0, 0, 4'hF, 3'd0, 14'h0000, 0, 0, 0});
    vecs.push_back('{  10, 1, 0, 4'hF, 3'd0, 14'h0000, 0, 0, 0});
    vecs.push_back('{  29, 1, 0, 4'hF, 3'd0, 14'h0000, 0, 0, 0});
    vecs.push_back('{  30, 1, 1, 4'h7, 3'd0, 14'h0000, 0, 0, 0});
    vecs.push_back('{  34, 1, 1, 4'h7, 3'd0, 14'h0000, 0, 0, 0});
    vecs.push_back('{  35, 1, 1, 4'h0, 3'd2, 14'h0008, 0, 0, 0});
    vecs.push_back('{  36, 1, 1, 4'h7, 3'd0, 14'h0000, 0, 0, 0});
    vecs.push_back('{  39, 1, 1, 4'h0, 3'd3, 14'h0004, 0, 0, 0});
    vecs.push_back('{  43, 1, 1, 4'h0, 3'd1, 14'h0044, 0, 0, 0});
    vecs.push_back('{  47, 1, 1, 4'h0, 3'd0, 14'h1520, 0, 0, 0});
    vecs.push_back('{  58, 1, 1, 4'h7, 3'd0, 14'h0000, 0, 0, 0});
    vecs.push_back('{  59, 1, 1, 4'h6, 3'd0, 14'h0400, 0, 0, 0});
    vecs.push_back('{  90, 1, 1, 4'h7, 3'd0, 14'h0000, 0, 0, 0});
    vecs.push_back('{  91, 1, 1, 4'h0, 3'd1, 14'h00C4, 0, 0, 0});
    vecs.push_back('{ 102, 1, 1, 4'h7, 3'd0, 14'h0000, 0, 0, 0});
    vecs.push_back('{ 103, 1, 1, 4'h7, 3'd0, 14'h0000, 1, 1, 0});
    vecs.push_back('{ 118, 1, 1, 4'h7, 3'd0, 14'h0000, 1, 1, 0});
    vecs.push_back('{ 119, 1, 1, 4'h0, 3'd1, 14'h0044, 0, 0, 0});
    vecs.push_back('{ 130, 1, 1, 4'h7, 3'd0, 14'h0000, 0, 0, 0});
    vecs.push_back('{ 131, 1, 1, 4'h7, 3'd0, 14'h0000, 0, 0, 1});
    vecs.push_back('{1131, 1, 1, 4'h7, 3'd0, 14'h0000, 0, 0, 1});

    // Full sequence plus 1000 cycles of DONE.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_seq(1131, -1);

    // Restart, then hit reset in the middle of the MRS block.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_seq(200, 45);

    // Release again; the sequence must replay with identical timing.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_seq(140, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
